// File: rtl/cache_read_controller_pkg.sv
// Shared types and defaults for the direct-mapped read cache controller.
package cache_pkg;

  localparam int unsigned CACHE_ADDR_W  = 15;
  localparam int unsigned CACHE_INDEX_W = 11;
  localparam int unsigned CACHE_TAG_W   = CACHE_ADDR_W - CACHE_INDEX_W - 2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    FILL,
    RESPOND
  } state_t;

  // Word k of a 4-word block sits at bits [32k+31:32k].
  function automatic logic [31:0] select_word(input logic [127:0] block,
                                              input logic [1:0]   offset);
    logic [31:0] word;
    unique case (offset)
      2'd0:    word = block[31:0];
      2'd1:    word = block[63:32];
      2'd2:    word = block[95:64];
      default: word = block[127:96];
    endcase
    return word;
  endfunction

endpackage

// File: rtl/cache_read_controller_store.sv
// Line storage for the cache: data, tag and valid arrays indexed by line.
module cache_store
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_W = CACHE_INDEX_W,
  parameter int unsigned TAG_W   = CACHE_TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  input  logic               fill,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic [127:0]       fill_block,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [127:0]       rd_block
);

  localparam int unsigned LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [127:0]     data_mem [LINES];

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= '0;
    end else if (fill) begin
      valid[index] <= 1'b1;
    end
  end

  // Tag and data contents survive reset; only valid bits are cleared.
  always_ff @(posedge clk) begin
    if (fill && rst) begin
      tag_mem[index]  <= fill_tag;
      data_mem[index] <= fill_block;
    end
  end

  assign rd_valid = valid[index];
  assign rd_tag   = tag_mem[index];
  assign rd_block = data_mem[index];

endmodule

// File: rtl/cache_read_controller.sv
// Direct-mapped read-only cache controller with block refill and hit/miss counters.
module cache_read_controller
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W  = CACHE_ADDR_W,
  parameter int unsigned INDEX_W = CACHE_INDEX_W,
  parameter int unsigned TAG_W   = ADDR_W - INDEX_W - 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic [31:0]       cpu_data,
  output logic              cpu_busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic              mem_data_ready,
  input  logic [127:0]      mem_block,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0]  addr_q;
  logic [1:0]         offset;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               saw_low;
  logic               fill;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [127:0]       rd_block;
  logic               hit;

  assign offset = addr_q[1:0];
  assign index  = addr_q[INDEX_W+1:2];
  assign tag    = addr_q[ADDR_W-1:INDEX_W+2];
  assign hit    = rd_valid && (rd_tag == tag);

  cache_store #(
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W)
  ) u_store (
    .clk       (clk),
    .rst       (rst),
    .index     (index),
    .fill      (fill),
    .fill_tag  (tag),
    .fill_block(mem_block),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_block  (rd_block)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (cpu_req) state_d = LOOKUP;
      LOOKUP:    state_d = hit ? RESPOND : MISS_REQ;
      MISS_REQ:  state_d = MISS_WAIT;
      // Only a rise seen after a low counts, so a level left high by the previous read is ignored.
      MISS_WAIT: if (mem_data_ready && saw_low) state_d = FILL;
      FILL:      state_d = RESPOND;
      RESPOND:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_ready = (state_q == RESPOND);
    cpu_busy  = (state_q != IDLE);
    fill      = (state_q == FILL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q      <= '0;
      cpu_data    <= '0;
      mem_address <= '0;
      mem_read    <= 1'b0;
      saw_low     <= 1'b0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (cpu_req) addr_q <= cpu_addr;
        LOOKUP: begin
          if (hit) begin
            cpu_data <= select_word(rd_block, offset);
            if (hit_count != '1) hit_count <= hit_count + 1'b1;
          end else begin
            if (miss_count != '1) miss_count <= miss_count + 1'b1;
            mem_address <= {addr_q[ADDR_W-1:2], 2'b00};
          end
        end
        MISS_REQ: begin
          mem_read <= 1'b1;
          saw_low  <= 1'b0;
        end
        MISS_WAIT: if (!mem_data_ready) saw_low <= 1'b1;
        FILL: begin
          mem_read <= 1'b0;
          cpu_data <= select_word(mem_block, offset);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_read_controller.sv
// Directed self-checking bench for cache_read_controller with a scripted main memory.
module tb_cache_read_controller;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned CNT_W  = 8;

  logic              clk;
  logic              rst;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ready;
  logic [31:0]       cpu_data;
  logic              cpu_busy;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_data_ready;
  logic [127:0]      mem_block;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  int checks = 0;
  int errors = 0;
  int h = 0;
  int m = 0;

  cache_read_controller #(
    .ADDR_W (ADDR_W),
    .INDEX_W(11),
    .TAG_W  (2),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req       (cpu_req),
    .cpu_addr      (cpu_addr),
    .cpu_ready     (cpu_ready),
    .cpu_data      (cpu_data),
    .cpu_busy      (cpu_busy),
    .mem_address   (mem_address),
    .mem_read      (mem_read),
    .mem_data_ready(mem_data_ready),
    .mem_block     (mem_block),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [ADDR_W-1:0] a);
    return {8'hA5, 9'h000, a};
  endfunction

  function automatic logic [127:0] blockof(input logic [ADDR_W-1:0] a);
    logic [127:0]      b;
    logic [ADDR_W-1:0] base;
    base = {a[ADDR_W-1:2], 2'b00};
    for (int k = 0; k < 4; k++) b[32*k +: 32] = memword(base + ADDR_W'(k));
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bump_hit();
    if (h < 255) h++;
  endtask

  task automatic do_hit(input logic [ADDR_W-1:0] a);
    cpu_addr = a;
    cpu_req  = 1'b1;
    tick();
    cpu_req = 1'b0;
    chk("hit_busy", 64'(cpu_busy), 64'd1);
    chk("hit_early_ready", 64'(cpu_ready), 64'd0);
    tick();
    bump_hit();
    chk("hit_ready", 64'(cpu_ready), 64'd1);
    chk("hit_data", 64'(cpu_data), 64'(memword(a)));
    chk("hit_mem_read", 64'(mem_read), 64'd0);
    chk("hit_count", 64'(hit_count), 64'(h));
    chk("hit_miss_count", 64'(miss_count), 64'(m));
    tick();
    chk("hit_ready_drop", 64'(cpu_ready), 64'd0);
    chk("hit_idle", 64'(cpu_busy), 64'd0);
  endtask

  // Runs a miss up to MISS_WAIT with mem_data_ready already driven low.
  task automatic miss_to_wait(input logic [ADDR_W-1:0] a, input bit stale);
    cpu_addr = a;
    cpu_req  = 1'b1;
    tick();
    cpu_req = 1'b0;
    chk("miss_busy", 64'(cpu_busy), 64'd1);
    tick();
    m++;
    chk("miss_address", 64'(mem_address), 64'({a[ADDR_W-1:2], 2'b00}));
    chk("miss_count_lookup", 64'(miss_count), 64'(m));
    tick();
    chk("miss_mem_read", 64'(mem_read), 64'd1);
    if (stale) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("stale_no_ready", 64'(cpu_ready), 64'd0);
        chk("stale_mem_read", 64'(mem_read), 64'd1);
        chk("stale_busy", 64'(cpu_busy), 64'd1);
      end
    end
    mem_data_ready = 1'b0;
    mem_block      = {4{32'hDEAD_BEEF}};
  endtask

  task automatic do_miss(input logic [ADDR_W-1:0] a, input bit stale);
    miss_to_wait(a, stale);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_mem_read", 64'(mem_read), 64'd1);
      chk("wait_no_ready", 64'(cpu_ready), 64'd0);
    end
    mem_block      = blockof(a);
    mem_data_ready = 1'b1;
    tick();
    chk("fill_no_ready", 64'(cpu_ready), 64'd0);
    tick();
    chk("miss_ready", 64'(cpu_ready), 64'd1);
    chk("miss_data", 64'(cpu_data), 64'(memword(a)));
    chk("miss_read_drop", 64'(mem_read), 64'd0);
    chk("miss_count", 64'(miss_count), 64'(m));
    chk("miss_hit_count", 64'(hit_count), 64'(h));
    tick();
    chk("miss_ready_drop", 64'(cpu_ready), 64'd0);
    chk("miss_idle", 64'(cpu_busy), 64'd0);
    chk("miss_data_held", 64'(cpu_data), 64'(memword(a)));
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    cpu_req        = 1'b0;
    cpu_addr       = '0;
    mem_data_ready = 1'b1;
    mem_block      = '0;
    repeat (3) tick();
    chk("rst_busy", 64'(cpu_busy), 64'd0);
    chk("rst_ready", 64'(cpu_ready), 64'd0);
    chk("rst_mem_read", 64'(mem_read), 64'd0);
    chk("rst_cpu_data", 64'(cpu_data), 64'd0);
    chk("rst_mem_address", 64'(mem_address), 64'd0);
    chk("rst_hit_count", 64'(hit_count), 64'd0);
    chk("rst_miss_count", 64'(miss_count), 64'd0);
    rst = 1'b1;
    tick();

    do_miss(15'h0005, 1'b0);
    do_hit(15'h0004);
    do_hit(15'h0006);
    do_hit(15'h0007);

    do_hit(15'h0005);
    do_miss(15'h2005, 1'b0);
    do_miss(15'h0005, 1'b0);
    chk("evict_miss_total", 64'(miss_count), 64'd3);

    do_miss(15'h2006, 1'b1);
    do_hit(15'h2004);

    // Reset held for 200 ns while the miss is outstanding.
    miss_to_wait(15'h0100, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_mem_read", 64'(mem_read), 64'd0);
    chk("midrst_busy", 64'(cpu_busy), 64'd0);
    repeat (19) tick();
    mem_block      = blockof(15'h0100);
    mem_data_ready = 1'b1;
    chk("midrst_hit_count", 64'(hit_count), 64'd0);
    chk("midrst_miss_count", 64'(miss_count), 64'd0);
    chk("midrst_cpu_data", 64'(cpu_data), 64'd0);
    chk("midrst_no_ready", 64'(cpu_ready), 64'd0);
    rst = 1'b1;
    h   = 0;
    m   = 0;
    tick();
    do_miss(15'h0100, 1'b0);
    do_miss(15'h0005, 1'b0);

    cpu_addr = 15'h0005;
    cpu_req  = 1'b1;
    for (int i = 0; i < 254; i++) repeat (3) tick();
    cpu_req = 1'b0;
    h = 254;
    chk("sat_pre", 64'(hit_count), 64'hFE);
    do_hit(15'h0005);
    chk("sat_max", 64'(hit_count), 64'hFF);
    do_hit(15'h0006);
    do_hit(15'h0007);
    chk("sat_hold", 64'(hit_count), 64'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
